// File: rtl/keypad_scanner_if.sv
// Keypad pin and key-report bundle between the matrix scanner and its consumer.
// master = scanner side (drives columns and key reports), slave = keypad/consumer side.
interface keypad_scanner_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (input row, output col, key_code, key_valid, key_held);
    modport slave  (output row, input col, key_code, key_valid, key_held);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotating active-low column drive, synchronized row sampling,
// whole-scan debouncing and single-key press reporting with a one-cycle strobe.
module keypad_scanner #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic             div_clock,
    input  logic             reset,
    keypad_scanner_if.master bus
);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int MW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [MW-1:0] MATCH_MAX   = MW'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {IDLE, ACCEPT, HELD} state_t;

    state_t        state_q, state_d;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [3:0]    sync1_q, sync2_q;
    logic [15:0]   snap_q, snap_d;
    logic [15:0]   prev_q, prev_d;
    logic [MW-1:0] match_q, match_d;
    logic [3:0]    col_q, col_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          key_held_q, key_held_d;

    logic          last_settle;
    logic          scan_done;
    logic          stable;
    logic [3:0]    key_idx;

    assign last_settle = (settle_q == SETTLE_LAST);
    assign scan_done   = last_settle && (col_idx_q == 2'd3);

    // Snapshot bit 4r+c holds the pressed state of row r seen while column c was driven.
    for (genvar gi = 0; gi < 16; gi++) begin : g_snap
        assign snap_d[gi] = (last_settle && (col_idx_q == 2'(gi % 4))) ? ~sync2_q[gi / 4]
                                                                        : snap_q[gi];
    end

    always_comb begin
        key_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (snap_d[i]) key_idx = 4'(i);
        end
    end

    always_comb begin
        settle_d  = last_settle ? '0 : settle_q + SW'(1);
        col_idx_d = last_settle ? col_idx_q + 2'd1 : col_idx_q;
        col_d     = ~(4'b0001 << col_idx_d);

        match_d = match_q;
        prev_d  = prev_q;
        if (scan_done) begin
            if (snap_d == prev_q) begin
                match_d = (match_q == MATCH_MAX) ? MATCH_MAX : match_q + MW'(1);
            end else begin
                match_d = MW'(1);
            end
            prev_d = snap_d;
        end
        // Uses the freshly computed count so the FSM reacts on the same completing edge.
        stable = scan_done && (match_d == MATCH_MAX);

        state_d     = state_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        case (state_q)
            IDLE: begin
                if (stable && $onehot(snap_d)) begin
                    state_d     = ACCEPT;
                    key_code_d  = key_idx;
                    key_valid_d = 1'b1;
                    key_held_d  = 1'b1;
                end
            end
            ACCEPT: begin
                state_d = HELD;
            end
            HELD: begin
                // Only a fully released, debounced keypad re-arms the detector.
                if (stable && (snap_d == 16'd0)) begin
                    state_d    = IDLE;
                    key_held_d = 1'b0;
                end
            end
            default: begin
                state_d    = IDLE;
                key_held_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge div_clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            col_idx_q   <= 2'd0;
            settle_q    <= '0;
            sync1_q     <= 4'b1111;
            sync2_q     <= 4'b1111;
            snap_q      <= 16'd0;
            prev_q      <= 16'd0;
            match_q     <= '0;
            col_q       <= 4'b1110;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_idx_q   <= col_idx_d;
            settle_q    <= settle_d;
            sync1_q     <= bus.row;
            sync2_q     <= sync1_q;
            snap_q      <= snap_d;
            prev_q      <= prev_d;
            match_q     <= match_d;
            col_q       <= col_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign bus.col       = col_q;
    assign bus.key_code  = key_code_q;
    assign bus.key_valid = key_valid_q;
    assign bus.key_held  = key_held_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a switch-matrix model closes rows onto driven columns,
// and per-cycle expectations are hand-derived from the scan/debounce timing.
module tb_keypad_scanner;
    logic        div_clock;
    logic        reset;
    logic [15:0] pressed;
    int          checks;
    int          errors;
    int          cur;
    logic [3:0]  col_pat [4];

    keypad_scanner_if kif ();

    keypad_scanner #(
        .SETTLE_CYCLES  (4),
        .DEBOUNCE_SCANS (4)
    ) dut (
        .div_clock (div_clock),
        .reset     (reset),
        .bus       (kif.master)
    );

    initial div_clock = 1'b0;
    always #5 div_clock = ~div_clock;

    // Pressed key at (r,c) pulls row r low whenever column c is driven low.
    always_comb begin
        kif.row = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[4*r+c] && !kif.col[c]) kif.row[r] = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cur, got, exp);
        end
    endtask

    // Leaves the bench at the negedge before edge 0; cur is the cycle whose values are visible.
    task automatic do_reset(input logic [15:0] keys);
        @(negedge div_clock);
        reset   = 1'b0;
        pressed = keys;
        repeat (3) @(negedge div_clock);
        reset = 1'b1;
        cur   = 0;
    endtask

    task automatic step();
        @(posedge div_clock);
        @(negedge div_clock);
        cur++;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        cur        = 0;
        reset      = 1'b0;
        pressed    = 16'd0;
        col_pat[0] = 4'b1110;
        col_pat[1] = 4'b1101;
        col_pat[2] = 4'b1011;
        col_pat[3] = 4'b0111;

        // Idle keypad: reset values, column rotation, no strobe.
        do_reset(16'd0);
        $display("test idle: reset values and column rotation");
        chk("rst_col", kif.col, 4'b1110);
        chk("rst_code", kif.key_code, 4'd0);
        chk("rst_valid", kif.key_valid, 1'b0);
        chk("rst_held", kif.key_held, 1'b0);
        for (int i = 0; i < 200; i++) begin
            if (i < 32) chk("col_seq", kif.col, col_pat[(i / 4) % 4]);
            chk("idle_valid", kif.key_valid, 1'b0);
            step();
        end

        // Key r1,c2 held from reset: single strobe in cycle 64.
        do_reset(16'h0040);
        $display("test press r1c2 from reset");
        for (int i = 0; i < 600; i++) begin
            chk("hold_valid", kif.key_valid, (i == 64) ? 1'b1 : 1'b0);
            if (i == 64) begin
                chk("hold_code", kif.key_code, 4'd6);
                chk("hold_held", kif.key_held, 1'b1);
            end
            if (i == 599) chk("hold_held_end", kif.key_held, 1'b1);
            step();
        end

        // Key r3,c3 bouncing on alternate scans for scans 0..5, steady from scan 6.
        do_reset(16'h8000);
        $display("test bounce r3c3");
        for (int i = 0; i < 200; i++) begin
            pressed = ((i / 16) < 6 && ((i / 16) % 2) == 1) ? 16'h0000 : 16'h8000;
            chk("bounce_valid", kif.key_valid, (i == 160) ? 1'b1 : 1'b0);
            if (i == 160) chk("bounce_code", kif.key_code, 4'd15);
            step();
        end

        // r0,c0 plus r2,c1 together, then r2,c1 released at scan 6.
        do_reset(16'h0201);
        $display("test two keys then release one");
        for (int i = 0; i < 200; i++) begin
            pressed = (i < 96) ? 16'h0201 : 16'h0001;
            chk("multi_valid", kif.key_valid, (i == 160) ? 1'b1 : 1'b0);
            if (i == 100) chk("multi_held", kif.key_held, 1'b0);
            if (i == 160) begin
                chk("multi_code", kif.key_code, 4'd0);
                chk("multi_held_acc", kif.key_held, 1'b1);
            end
            step();
        end

        // r0,c1 press, release at scan 8, re-press at scan 16.
        do_reset(16'h0002);
        $display("test press release repress r0c1");
        for (int i = 0; i < 340; i++) begin
            pressed = (i < 128 || i >= 256) ? 16'h0002 : 16'h0000;
            chk("rel_valid", kif.key_valid, (i == 64 || i == 320) ? 1'b1 : 1'b0);
            chk("rel_held", kif.key_held, ((i >= 64 && i < 192) || i >= 320) ? 1'b1 : 1'b0);
            if (i == 64 || i == 250 || i == 320) chk("rel_code", kif.key_code, 4'd1);
            step();
        end

        // Asynchronous reset while HELD with r1,c1 still pressed.
        do_reset(16'h0020);
        $display("test async reset in HELD");
        while (cur < 80) step();
        chk("pre_rst_held", kif.key_held, 1'b1);
        chk("pre_rst_code", kif.key_code, 4'd5);
        #2;
        reset = 1'b0;
        #1;
        chk("async_col", kif.col, 4'b1110);
        chk("async_code", kif.key_code, 4'd0);
        chk("async_valid", kif.key_valid, 1'b0);
        chk("async_held", kif.key_held, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge div_clock);
            chk("in_rst_valid", kif.key_valid, 1'b0);
            chk("in_rst_col", kif.col, 4'b1110);
        end
        reset = 1'b1;
        cur   = 0;
        for (int i = 0; i < 100; i++) begin
            chk("rearm_valid", kif.key_valid, (i == 64) ? 1'b1 : 1'b0);
            if (i == 64) chk("rearm_code", kif.key_code, 4'd5);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
